// File: rtl/dot_product_ctrl.sv
// rtl/dot_product_ctrl.sv - sequences operand pairs through an external multiplier and accumulates a signed dot product
module dot_product_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic        elem_valid,
    input  logic [7:0]  elem_a,
    input  logic [7:0]  elem_b,
    output logic        elem_ready,
    output logic        mul_ready,
    output logic [7:0]  mul_data1,
    output logic [7:0]  mul_data2,
    input  logic [15:0] mul_result,
    input  logic        mul_done,
    output logic [19:0] sum,
    output logic        sum_valid,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    MAX_LEN_4 = 4'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [3:0]    len_q;
    logic [3:0]    cnt;
    logic [19:0]   acc;
    logic [TW-1:0] tcnt;
    logic [19:0]   product_ext;
    logic [19:0]   acc_next;

    assign product_ext = {{4{mul_result[15]}}, mul_result};
    assign acc_next    = acc + product_ext;

    // Every output is a flop; handshake strobes are set on the edge entering the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            acc        <= '0;
            tcnt       <= '0;
            sum        <= '0;
            sum_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            elem_ready <= 1'b0;
            mul_ready  <= 1'b0;
            mul_data1  <= '0;
            mul_data2  <= '0;
        end else begin
            sum_valid <= 1'b0;
            mul_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len == 4'd0) begin
                            sum       <= '0;
                            sum_valid <= 1'b1;
                        end else begin
                            len_q      <= (len > MAX_LEN_4) ? MAX_LEN_4 : len;
                            acc        <= '0;
                            cnt        <= '0;
                            state      <= FETCH;
                            busy       <= 1'b1;
                            elem_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (elem_valid) begin
                        mul_data1  <= elem_a;
                        mul_data2  <= elem_b;
                        elem_ready <= 1'b0;
                        mul_ready  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done is only trusted here: the multiplier clears it on the mul_ready pulse.
                    if (mul_done) begin
                        acc <= acc_next;
                        cnt <= cnt + 4'd1;
                        if (cnt == len_q - 4'd1) begin
                            sum       <= acc_next;
                            sum_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            elem_ready <= 1'b1;
                            state      <= FETCH;
                        end
                    end else if (tcnt == TO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, max element pairs per dot product.
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles in WAIT before abort.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request new dot product; sampled in IDLE only.
REQ-006 len  input  4  element-pair count, unsigned, latched with start.
REQ-007 elem_valid  input  1  upstream operand pair valid.
REQ-008 elem_a  input  8  signed operand A.
REQ-009 elem_b  input  8  signed operand B.
REQ-010 elem_ready  output  1  controller accepts operand pair this cycle.
REQ-011 mul_ready  output  1  one-cycle start pulse to the shift-add multiplier.
REQ-012 mul_data1  output  8  signed operand A held for multiplier.
REQ-013 mul_data2  output  8  signed operand B held for multiplier.
REQ-014 mul_result  input  16  multiplier product, interpreted as signed two's complement.
REQ-015 mul_done  input  1  multiplier done level; cleared by multiplier on accepting mul_ready.
REQ-016 sum  output  20  signed dot-product result.
REQ-017 sum_valid  output  1  one-cycle pulse; sum valid.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 err  output  1  sticky timeout flag, cleared on next accepted start.

Function
REQ-020 SHALL implement states IDLE, FETCH, ISSUE, WAIT; all outputs registered.
REQ-021 IDLE, start=1, len 1..MAX_LEN: latch len, acc=0, cnt=0, err=0, go FETCH.
REQ-022 IDLE, start=1, len>MAX_LEN: SHALL saturate latched len to MAX_LEN.
REQ-023 IDLE, start=1, len=0: sum=0, sum_valid=1 next cycle, remain IDLE, err=0.
REQ-024 start while busy SHALL be ignored with no effect.
REQ-025 FETCH: elem_ready=1; on elem_valid=1 capture elem_a/elem_b into mul_data1/mul_data2, go ISSUE; else hold.
REQ-026 elem_ready SHALL be 0 in all states except FETCH.
REQ-027 ISSUE: mul_ready=1 for exactly one cycle, go WAIT; mul_data1/2 stable until next FETCH handshake.
REQ-028 WAIT: on mul_done=1, acc += sign-extended mul_result (20-bit), cnt++.
REQ-029 WAIT accumulate with cnt==len-1: sum=acc+product, sum_valid=1 one cycle, go IDLE; else go FETCH.
REQ-030 mul_done SHALL be ignored outside WAIT; any stale done is overwritten by multiplier clear during ISSUE.
REQ-031 Per-element period with elem_valid held high: 12 cycles (FETCH 1, ISSUE 1, WAIT 10).
REQ-032 sum_valid SHALL rise 12*N cycles after the edge accepting start, N = latched len.
REQ-033 20-bit acc SHALL never overflow: |sum| <= 8*16384 = 131072.
REQ-034 WAIT timeout counter: reset on WAIT entry; after TIMEOUT cycles without mul_done, err=1, go IDLE, no sum_valid, sum unchanged.
REQ-035 sum SHALL hold last value until next completion or reset.

Reset
REQ-036 rst=0 SHALL immediately force IDLE, acc=0, cnt=0, sum=0, sum_valid=0, busy=0, err=0, elem_ready=0, mul_ready=0, mul_data1=0, mul_data2=0.
REQ-037 Reset mid-operation SHALL abandon the partial sum; first start after release behaves as from power-up.
REQ-038 Controller SHALL not depend on multiplier reset state; first mul_done after each mul_ready only.

Verification
REQ-039 len=3, pairs (3,4),(-5,6),(-128,-128), elem_valid always 1 -> sum=16366, sum_valid pulse 36 cycles after start.
REQ-040 len=8, all pairs (-128,-128) -> sum=131072, no wrap; len=8 all (-128,127) -> sum=-130048.
REQ-041 len=0 -> sum=0, sum_valid next cycle, busy never high; len=12 with 8 pairs (1,1) -> sum=8.
REQ-042 len=2, elem_valid withheld 5 cycles before each pair -> elem_ready held high, sum correct, latency +10.
REQ-043 mul_done tied 0 after first ISSUE -> err=1 after 16 WAIT cycles, IDLE, no sum_valid.
REQ-044 rst=0 during WAIT of second element, then new start len=1 (2,3) -> all outputs reset, then sum=6.
